// File: rtl/hd44780_arbiter.sv
// ---------------------------------------------------------------------------
// hd44780_arbiter
//
// Shares one 4-bit HD44780 bus between two byte-level requesters. Each
// accepted byte goes onto the bus as two nibble strobes on e (high nibble
// first), followed by a busy wait long enough for the controller to execute
// it. Clear/home commands get the long wait. Every other byte gets the short
// wait. Runs in the 250 kHz bus clock domain (4 us per cycle).
//
// Arbitration is round-robin with a one-byte grant. A lone requester always
// wins. On a tie, the requester that was not granted last wins.
//
// Handshake: reqN_ready is combinational and is high only in IDLE, only for
// the arbitration winner, and only while rst is low. A byte transfers on the
// clock edge where reqN_valid && reqN_ready. The requester must hold valid,
// rs and data stable until it sees ready. A valid dropped before ready is
// simply ignored.
//
// Parameters:
//   SHORT_WAIT  post-transfer wait (cycles) for normal commands and data
//   LONG_WAIT   post-transfer wait (cycles) for clear/home commands
//   Both waits must be >= 1. SHORT_WAIT must not exceed LONG_WAIT.
//
// Ports:
//   clk                   250 kHz bus clock
//   rst                   synchronous active-high reset
//   req0_valid/rs/data    requester 0 byte offer (rs: 0 = command, 1 = data)
//   req0_ready            requester 0 byte accepted this cycle
//   req1_*                same as requester 0, for requester 1
//   e                     HD44780 enable strobe
//   rs                    HD44780 register select
//   db[3:0]               HD44780 data nibble (DB7..DB4)
//   busy                  high in every state except IDLE
//   grant                 index of the last accepted requester
// ---------------------------------------------------------------------------
module hd44780_arbiter #(
    parameter int SHORT_WAIT = 10,
    parameter int LONG_WAIT  = 400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       e,
    output logic       rs,
    output logic [3:0] db,
    output logic       busy,
    output logic       grant
);

    localparam int CW = $clog2(LONG_WAIT + 1);

    // Counter loads with W-1, so WAIT lasts exactly W cycles.
    localparam logic [CW-1:0] SHORT_LOAD = CW'(SHORT_WAIT - 1);
    localparam logic [CW-1:0] LONG_LOAD  = CW'(LONG_WAIT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP_H = 3'd1;
    localparam logic [2:0] S_PULSE_H = 3'd2;
    localparam logic [2:0] S_HOLD_H  = 3'd3;
    localparam logic [2:0] S_SETUP_L = 3'd4;
    localparam logic [2:0] S_PULSE_L = 3'd5;
    localparam logic [2:0] S_HOLD_L  = 3'd6;
    localparam logic [2:0] S_WAIT    = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [7:0]    data_q,  data_d;
    logic          rs_q,    rs_d;
    logic [3:0]    db_q,    db_d;
    logic          e_q,     e_d;
    logic          grant_q, grant_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic idle;
    logic win0;
    logic win1;
    logic long_cmd;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign idle = (state_q == S_IDLE);

    // grant_q holds the last winner. On a tie the other requester wins.
    assign win0 = req0_valid && (!req1_valid || grant_q);
    assign win1 = req1_valid && (!req0_valid || !grant_q);

    assign req0_ready = idle && !rst && win0;
    assign req1_ready = idle && !rst && win1;

    // Clear (0x01) and home (0x02/0x03) are the only slow commands.
    // rs_q still holds the latched rs at this point.
    assign long_cmd = !rs_q && (data_q[7:2] == 6'd0);

    // ------------------------------------------------------------------
    // Next-state logic
    // rs/db change only when entering SETUP_H or SETUP_L. This leaves at
    // least one full cycle of setup and one of hold around each e pulse.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rs_d    = rs_q;
        db_d    = db_q;
        e_d     = 1'b0;
        grant_d = grant_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req0_ready) begin
                    data_d  = req0_data;
                    rs_d    = req0_rs;
                    db_d    = req0_data[7:4];
                    grant_d = 1'b0;
                    state_d = S_SETUP_H;
                end else if (req1_ready) begin
                    data_d  = req1_data;
                    rs_d    = req1_rs;
                    db_d    = req1_data[7:4];
                    grant_d = 1'b1;
                    state_d = S_SETUP_H;
                end
            end
            S_SETUP_H: begin
                e_d     = 1'b1;
                state_d = S_PULSE_H;
            end
            S_PULSE_H: begin
                state_d = S_HOLD_H;
            end
            S_HOLD_H: begin
                db_d    = data_q[3:0];
                state_d = S_SETUP_L;
            end
            S_SETUP_L: begin
                e_d     = 1'b1;
                state_d = S_PULSE_L;
            end
            S_PULSE_L: begin
                state_d = S_HOLD_L;
            end
            S_HOLD_L: begin
                cnt_d   = long_cmd ? LONG_LOAD : SHORT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers. Reset drops any in-flight byte immediately.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            db_q    <= 4'h0;
            e_q     <= 1'b0;
            grant_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            e_q     <= e_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign e     = e_q;
    assign rs    = rs_q;
    assign db    = db_q;
    assign busy  = !idle;
    assign grant = grant_q;

endmodule

// File: tb/tb_hd44780_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hd44780_arbiter
//
// Directed bench for hd44780_arbiter. Inputs are driven just after the
// falling edge. Outputs are sampled 1 time unit after the falling edge, well
// away from the rising (active) edge. Cycle numbering follows the
// accept-edge convention: cycle 0 is the cycle in which ready is high, and
// cycle 1 is the first SETUP_H cycle.
// ---------------------------------------------------------------------------
module tb_hd44780_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid;
    logic       req0_rs;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic       req1_rs;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       e;
    logic       rs;
    logic [3:0] db;
    logic       busy;
    logic       grant;

    int checks = 0;
    int passes = 0;

    // Byte sequence table: requester, rs, data, expected wait length.
    int         t_req [5] = '{0, 1, 0, 1, 0};
    logic       t_rs  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] t_d   [5] = '{8'h41, 8'h01, 8'h03, 8'h04, 8'h01};
    int         t_w   [5] = '{10, 400, 400, 10, 10};

    always #5 clk = ~clk;

    hd44780_arbiter #(
        .SHORT_WAIT(10),
        .LONG_WAIT (400)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_rs   (req0_rs),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_rs   (req1_rs),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .e         (e),
        .rs        (rs),
        .db        (db),
        .busy      (busy),
        .grant     (grant)
    );

    // Expected {e, rs, db, busy} for cycle c (c >= 1) of a transfer.
    function automatic logic [6:0] exp_bus(int c, logic r, logic [7:0] d, int w);
        logic       e_x;
        logic       busy_x;
        logic [3:0] db_x;
        e_x    = (c == 2) || (c == 5);
        busy_x = (c <= 6 + w);
        db_x   = (c <= 3) ? d[7:4] : d[3:0];
        return {e_x, r, db_x, busy_x};
    endfunction

    task automatic test_reset();
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_rs    = 1'b1;
        req0_data  = 8'h41;
        req1_valid = 1'b0;
        req1_rs    = 1'b0;
        req1_data  = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({e, rs, db, busy, grant, req0_ready, req1_ready} !== 10'b0_0_0000_0_1_0_0)
                $display("FAIL reset_state cyc=%0d got=%b exp=%b", i,
                         {e, rs, db, busy, grant, req0_ready, req1_ready}, 10'b0_0_0000_0_1_0_0);
            else
                passes++;
        end
    endtask

    // Back-to-back bytes covering data, clear, home and short-wait boundaries.
    // The active requester keeps valid high throughout, which shows it is
    // stalled while busy and accepted again exactly at cycle 7+W.
    task automatic test_byte_sequence();
        logic [1:0] exp_rdy;
        logic [6:0] exp_b;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (t_req[i] == 0) begin
                req0_valid = 1'b1;
                req0_rs    = t_rs[i];
                req0_data  = t_d[i];
            end else begin
                req1_valid = 1'b1;
                req1_rs    = t_rs[i];
                req1_data  = t_d[i];
            end
            #1;
            exp_rdy = (t_req[i] == 1) ? 2'b10 : 2'b01;
            checks++;
            if ({req1_ready, req0_ready} !== exp_rdy)
                $display("FAIL seq_accept i=%0d got=%b exp=%b", i, {req1_ready, req0_ready}, exp_rdy);
            else
                passes++;
            for (int c = 1; c <= 7 + t_w[i]; c++) begin
                @(negedge clk);
                #1;
                exp_b = exp_bus(c, t_rs[i], t_d[i], t_w[i]);
                checks++;
                if ({e, rs, db, busy} !== exp_b)
                    $display("FAIL seq_bus i=%0d c=%0d got=%b exp=%b", i, c, {e, rs, db, busy}, exp_b);
                else
                    passes++;
                checks++;
                if (grant !== t_req[i][0])
                    $display("FAIL seq_grant i=%0d c=%0d got=%b exp=%b", i, c, grant, t_req[i][0]);
                else
                    passes++;
                exp_rdy = (c == 7 + t_w[i]) ? ((t_req[i] == 1) ? 2'b10 : 2'b01) : 2'b00;
                checks++;
                if ({req1_ready, req0_ready} !== exp_rdy)
                    $display("FAIL seq_ready i=%0d c=%0d got=%b exp=%b", i, c, {req1_ready, req0_ready}, exp_rdy);
                else
                    passes++;
            end
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_rdy;
        int k;
        int ph;
        rst       = 1'b1;
        req0_rs   = 1'b1;
        req0_data = 8'hAA;
        req1_rs   = 1'b1;
        req1_data = 8'h55;
        @(negedge clk);
        rst        = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int c = 0; c < 68; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            k  = c / 17;
            ph = c % 17;
            exp_rdy = (ph != 0) ? 2'b00 : ((k % 2 == 1) ? 2'b10 : 2'b01);
            checks++;
            if ({req1_ready, req0_ready} !== exp_rdy)
                $display("FAIL cont_ready c=%0d got=%b exp=%b", c, {req1_ready, req0_ready}, exp_rdy);
            else
                passes++;
            if (ph == 1) begin
                checks++;
                if ({grant, db} !== ((k % 2 == 1) ? 5'b1_0101 : 5'b0_1010))
                    $display("FAIL cont_grant c=%0d got=%b exp=%b", c, {grant, db},
                             (k % 2 == 1) ? 5'b1_0101 : 5'b0_1010);
                else
                    passes++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int n = 0; n < 500 && busy; n++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (busy !== 1'b0)
            $display("FAIL cont_idle_timeout got=%b exp=0", busy);
        else
            passes++;
    endtask

    task automatic test_streaming();
        logic [1:0] exp_rdy;
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_rs    = 1'b1;
        req1_data  = 8'h30;
        for (int c = 0; c < 68; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_rdy = (c % 17 == 0) ? 2'b10 : 2'b00;
            checks++;
            if ({req1_ready, req0_ready} !== exp_rdy)
                $display("FAIL stream_ready c=%0d got=%b exp=%b", c, {req1_ready, req0_ready}, exp_rdy);
            else
                passes++;
            checks++;
            if (grant !== 1'b1)
                $display("FAIL stream_grant c=%0d got=%b exp=1", c, grant);
            else
                passes++;
        end
        req1_valid = 1'b0;
        for (int n = 0; n < 500 && busy; n++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (busy !== 1'b0)
            $display("FAIL stream_idle_timeout got=%b exp=0", busy);
        else
            passes++;
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1;
        req0_rs    = 1'b1;
        req0_data  = 8'h5A;
        #1;
        checks++;
        if (req0_ready !== 1'b1)
            $display("FAIL mid_accept got=%b exp=1", req0_ready);
        else
            passes++;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if ({e, rs, db, busy, grant} !== 8'b1_1_1010_1_0)
            $display("FAIL mid_pulse_l got=%b exp=%b", {e, rs, db, busy, grant}, 8'b1_1_1010_1_0);
        else
            passes++;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({e, rs, db, busy, grant, req0_ready} !== 9'b0_0_0000_0_1_0)
            $display("FAIL mid_after_rst got=%b exp=%b", {e, rs, db, busy, grant, req0_ready},
                     9'b0_0_0000_0_1_0);
        else
            passes++;
        rst = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b1)
            $display("FAIL mid_reaccept got=%b exp=1", req0_ready);
        else
            passes++;
        @(negedge clk);
        #1;
        req0_valid = 1'b0;
        checks++;
        if ({busy, rs, db, grant, e} !== 8'b1_1_0101_0_0)
            $display("FAIL mid_setup_h got=%b exp=%b", {busy, rs, db, grant, e}, 8'b1_1_0101_0_0);
        else
            passes++;
        for (int n = 0; n < 500 && busy; n++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (busy !== 1'b0)
            $display("FAIL mid_idle_timeout got=%b exp=0", busy);
        else
            passes++;
    endtask

    initial begin
        test_reset();
        test_byte_sequence();
        test_contention();
        test_streaming();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
